// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA copy engine and its data buffer.
package dma_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_CMD,
      WR_CMD,
      DATA,
      WAIT_BACK,
      DONE
   } dma_state_t;

   // Number of data beats covered by a byte length (length is beat aligned).
   function automatic logic [31:0] beats(input logic [31:0] len, input int unsigned beat_shift);
      return len >> beat_shift;
   endfunction

   // Size of the next burst: whatever remains, capped at the largest allowed burst.
   function automatic logic [31:0] burst_len(input logic [31:0] rem, input logic [31:0] max_len);
      return (rem < max_len) ? rem : max_len;
   endfunction

endpackage

// File: rtl/dma_beat_fifo.sv
// Read-to-write beat buffer: a plain synchronous FIFO with valid/ready on both sides.
// Pointers carry one extra wrap bit so full and empty can be told apart without a counter.
module dma_beat_fifo
   import dma_pkg::*;
#(
   parameter int WIDTH = 513,
   parameter int DEPTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;

   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty     = (wr_ptr == rd_ptr);
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign push      = in_valid && !full;
   assign pop       = out_ready && !empty;
   assign out_data  = mem[rd_ptr[AW-1:0]];

   // Storage array; written only, never reset, since occupancy is tracked by the pointers.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= in_data;
      end
   end

   // Pointer update; reset empties the buffer and drops any beats still held.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/dma_copy_engine.sv
// Initiator-side DMA mover. A job (src, dst, length) is cut into bursts of at most
// MAX_BURST_BYTES; for each burst a read command and a write command are issued, the
// returned read beats are buffered and replayed as write beats, and after the last burst
// the engine waits for every write completion before reporting the job as done.
module dma_copy_engine
   import dma_pkg::*;
#(
   parameter int WIDTH           = 512,
   parameter int MAX_BURST_BYTES = 4096,
   parameter int FIFO_DEPTH      = 16
) (
   input  logic               clock,
   input  logic               reset,

   input  logic               job_valid,
   output logic               job_ready,
   input  logic [63:0]        job_src_addr,
   input  logic [63:0]        job_dst_addr,
   input  logic [31:0]        job_length,

   output logic               read_cmd_valid,
   input  logic               read_cmd_ready,
   output logic [63:0]        read_cmd_address,
   output logic [31:0]        read_cmd_length,

   output logic               write_cmd_valid,
   input  logic               write_cmd_ready,
   output logic [63:0]        write_cmd_address,
   output logic [31:0]        write_cmd_length,

   input  logic               read_data_valid,
   output logic               read_data_ready,
   input  logic [WIDTH-1:0]   read_data_data,
   input  logic [WIDTH/8-1:0] read_data_keep,
   input  logic               read_data_last,

   output logic               write_data_valid,
   input  logic               write_data_ready,
   output logic [WIDTH-1:0]   write_data_data,
   output logic [WIDTH/8-1:0] write_data_keep,
   output logic               write_data_last,

   input  logic               back_valid,
   output logic               back_ready,

   output logic               done_valid,
   input  logic               done_ready,
   output logic [31:0]        done_bursts,
   output logic               done_error
);

   localparam int          BEAT_BYTES = WIDTH / 8;
   localparam int          BEAT_SHIFT = $clog2(BEAT_BYTES);
   localparam logic [31:0] LEN_MASK   = ~(32'(BEAT_BYTES) - 32'd1);
   localparam logic [31:0] MAX_LEN    = 32'(MAX_BURST_BYTES);

   dma_state_t  state;
   logic [63:0] src;
   logic [63:0] dst;
   logic [31:0] rem;
   logic [31:0] blen;
   logic [31:0] bursts;
   logic [31:0] wr_cnt;
   logic [31:0] outstanding;
   logic        error;

   logic        fifo_in_ready;
   logic        fifo_out_valid;
   logic        fifo_out_ready;
   logic [WIDTH:0] fifo_out_data;

   logic        in_data_state;
   logic        job_fire;
   logic        rd_cmd_fire;
   logic        wr_cmd_fire;
   logic        wr_fire;
   logic        last_beat;
   logic        last_fire;
   logic        back_counts;
   logic [31:0] job_rem;
   logic [31:0] next_rem;
   logic [31:0] first_blen;
   logic [31:0] next_blen;
   logic [63:0] next_src;
   logic [63:0] next_dst;
   logic        unused_keep;

   // The read-side byte enables carry no information for a whole-beat copy.
   assign unused_keep = ^read_data_keep;

   // Each buffered entry is the read beat plus the read_data_last flag that came with it,
   // so framing of the read stream can be checked when the beat is replayed.
   dma_beat_fifo #(
      .WIDTH (WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (read_data_valid),
      .in_ready  (fifo_in_ready),
      .in_data   ({read_data_last, read_data_data}),
      .out_valid (fifo_out_valid),
      .out_ready (fifo_out_ready),
      .out_data  (fifo_out_data)
   );

   assign in_data_state    = (state == DATA);
   assign read_data_ready  = fifo_in_ready;
   assign write_data_valid = fifo_out_valid && in_data_state;
   assign fifo_out_ready   = write_data_ready && in_data_state;
   assign write_data_data  = fifo_out_data[WIDTH-1:0];
   assign write_data_keep  = '1;
   assign last_beat        = (wr_cnt == beats(blen, BEAT_SHIFT) - 32'd1);
   assign write_data_last  = last_beat;

   assign job_fire    = job_valid && job_ready;
   assign rd_cmd_fire = read_cmd_valid && read_cmd_ready;
   assign wr_cmd_fire = write_cmd_valid && write_cmd_ready;
   assign wr_fire     = write_data_valid && write_data_ready;
   assign last_fire   = wr_fire && last_beat;
   assign back_counts = back_valid && back_ready && (outstanding != 32'd0);

   assign job_rem    = job_length & LEN_MASK;
   assign first_blen = burst_len(job_rem, MAX_LEN);
   assign next_rem   = rem - blen;
   assign next_blen  = burst_len(next_rem, MAX_LEN);
   assign next_src   = src + {32'd0, blen};
   assign next_dst   = dst + {32'd0, blen};

   assign done_bursts = bursts;
   assign done_error  = error;

   // Completions are always accepted once out of reset; stray ones are simply dropped.
   always_ff @(posedge clock) begin
      if (reset) begin
         back_ready <= 1'b0;
      end else begin
         back_ready <= 1'b1;
      end
   end

   // Count of write bursts whose data is sent but whose completion has not come back.
   always_ff @(posedge clock) begin
      if (reset) begin
         outstanding <= '0;
      end else begin
         case ({last_fire, back_counts})
            2'b10:   outstanding <= outstanding + 32'd1;
            2'b01:   outstanding <= outstanding - 32'd1;
            default: outstanding <= outstanding;
         endcase
      end
   end

   // Job sequencer: walks each burst through read command, write command and data phase,
   // then drains completions and presents the job result until it is taken.
   always_ff @(posedge clock) begin
      if (reset) begin
         state             <= IDLE;
         job_ready         <= 1'b0;
         read_cmd_valid    <= 1'b0;
         read_cmd_address  <= '0;
         read_cmd_length   <= '0;
         write_cmd_valid   <= 1'b0;
         write_cmd_address <= '0;
         write_cmd_length  <= '0;
         done_valid        <= 1'b0;
         src               <= '0;
         dst               <= '0;
         rem               <= '0;
         blen              <= '0;
         bursts            <= '0;
         wr_cnt            <= '0;
         error             <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               job_ready <= 1'b1;
               if (job_fire) begin
                  job_ready <= 1'b0;
                  src       <= job_src_addr;
                  dst       <= job_dst_addr;
                  rem       <= job_rem;
                  bursts    <= '0;
                  error     <= 1'b0;
                  if (job_rem == 32'd0) begin
                     state      <= DONE;
                     done_valid <= 1'b1;
                  end else begin
                     state            <= RD_CMD;
                     blen             <= first_blen;
                     read_cmd_valid   <= 1'b1;
                     read_cmd_address <= job_src_addr;
                     read_cmd_length  <= first_blen;
                  end
               end
            end

            RD_CMD: begin
               if (rd_cmd_fire) begin
                  state             <= WR_CMD;
                  read_cmd_valid    <= 1'b0;
                  write_cmd_valid   <= 1'b1;
                  write_cmd_address <= dst;
                  write_cmd_length  <= blen;
               end
            end

            WR_CMD: begin
               if (wr_cmd_fire) begin
                  state           <= DATA;
                  write_cmd_valid <= 1'b0;
                  wr_cnt          <= '0;
               end
            end

            DATA: begin
               if (wr_fire) begin
                  if (fifo_out_data[WIDTH] != last_beat) begin
                     error <= 1'b1;
                  end
                  if (last_beat) begin
                     wr_cnt <= '0;
                     rem    <= next_rem;
                     src    <= next_src;
                     dst    <= next_dst;
                     bursts <= bursts + 32'd1;
                     if (next_rem != 32'd0) begin
                        state            <= RD_CMD;
                        blen             <= next_blen;
                        read_cmd_valid   <= 1'b1;
                        read_cmd_address <= next_src;
                        read_cmd_length  <= next_blen;
                     end else begin
                        state <= WAIT_BACK;
                     end
                  end else begin
                     wr_cnt <= wr_cnt + 32'd1;
                  end
               end
            end

            WAIT_BACK: begin
               if (outstanding == 32'd0) begin
                  state      <= DONE;
                  done_valid <= 1'b1;
               end
            end

            DONE: begin
               if (done_valid && done_ready) begin
                  state      <= IDLE;
                  done_valid <= 1'b0;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Directed testbench for dma_copy_engine with a small memory responder: read data beats
// carry their own byte address replicated across the bus, completions return a fixed
// number of cycles after each final write beat.
module tb_dma_copy_engine;

   localparam int WIDTH = 512;

   logic               clock = 1'b0;
   logic               reset = 1'b1;
   logic               job_valid, job_ready;
   logic [63:0]        job_src_addr, job_dst_addr;
   logic [31:0]        job_length;
   logic               read_cmd_valid, read_cmd_ready;
   logic [63:0]        read_cmd_address;
   logic [31:0]        read_cmd_length;
   logic               write_cmd_valid, write_cmd_ready;
   logic [63:0]        write_cmd_address;
   logic [31:0]        write_cmd_length;
   logic               read_data_valid, read_data_ready;
   logic [WIDTH-1:0]   read_data_data;
   logic [WIDTH/8-1:0] read_data_keep;
   logic               read_data_last;
   logic               write_data_valid, write_data_ready;
   logic [WIDTH-1:0]   write_data_data;
   logic [WIDTH/8-1:0] write_data_keep;
   logic               write_data_last;
   logic               back_valid, back_ready;
   logic               done_valid, done_ready;
   logic [31:0]        done_bursts;
   logic               done_error;

   dma_copy_engine #(.WIDTH(WIDTH), .MAX_BURST_BYTES(4096), .FIFO_DEPTH(16)) dut (
      .clock(clock), .reset(reset),
      .job_valid(job_valid), .job_ready(job_ready),
      .job_src_addr(job_src_addr), .job_dst_addr(job_dst_addr), .job_length(job_length),
      .read_cmd_valid(read_cmd_valid), .read_cmd_ready(read_cmd_ready),
      .read_cmd_address(read_cmd_address), .read_cmd_length(read_cmd_length),
      .write_cmd_valid(write_cmd_valid), .write_cmd_ready(write_cmd_ready),
      .write_cmd_address(write_cmd_address), .write_cmd_length(write_cmd_length),
      .read_data_valid(read_data_valid), .read_data_ready(read_data_ready),
      .read_data_data(read_data_data), .read_data_keep(read_data_keep),
      .read_data_last(read_data_last),
      .write_data_valid(write_data_valid), .write_data_ready(write_data_ready),
      .write_data_data(write_data_data), .write_data_keep(write_data_keep),
      .write_data_last(write_data_last),
      .back_valid(back_valid), .back_ready(back_ready),
      .done_valid(done_valid), .done_ready(done_ready),
      .done_bursts(done_bursts), .done_error(done_error)
   );

   int checks_total  = 0;
   int checks_passed = 0;
   int cycle_count   = 0;
   int back_delay    = 10;
   int bad_last_beat = -1;

   logic [63:0]      rd_cmd_addr_q[$];
   logic [31:0]      rd_cmd_len_q[$];
   logic [63:0]      wr_cmd_addr_q[$];
   logic [31:0]      wr_cmd_len_q[$];
   logic [WIDTH-1:0] wr_data_q[$];
   logic             wr_last_q[$];
   logic [63:0]      pend_addr_q[$];
   logic [31:0]      pend_len_q[$];
   int               back_due_q[$];
   int               rd_beat_count = 0;
   int               back_count    = 0;
   int               keep_bad      = 0;

   initial forever #5 clock = ~clock;

   initial forever begin
      @(posedge clock);
      cycle_count++;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Bus monitor: records every handshake that will complete at the coming clock edge.
   initial forever begin
      @(negedge clock);
      if (!reset) begin
         if (read_cmd_valid && read_cmd_ready) begin
            rd_cmd_addr_q.push_back(read_cmd_address);
            rd_cmd_len_q.push_back(read_cmd_length);
            pend_addr_q.push_back(read_cmd_address);
            pend_len_q.push_back(read_cmd_length);
         end
         if (write_cmd_valid && write_cmd_ready) begin
            wr_cmd_addr_q.push_back(write_cmd_address);
            wr_cmd_len_q.push_back(write_cmd_length);
         end
         if (read_data_valid && read_data_ready) rd_beat_count++;
         if (write_data_valid && write_data_ready) begin
            wr_data_q.push_back(write_data_data);
            wr_last_q.push_back(write_data_last);
            if (write_data_keep !== '1) keep_bad++;
            if (write_data_last) back_due_q.push_back(cycle_count + back_delay);
         end
         if (back_valid && back_ready) begin
            back_count++;
            if (back_due_q.size() > 0) void'(back_due_q.pop_front());
         end
      end
   end

   // Memory read responder: plays one burst at a time from the accepted read commands.
   initial begin : responder
      logic [63:0] cur_addr;
      int          total;
      int          idx;
      bit          active;
      bit          fire;
      read_data_valid = 1'b0;
      read_data_data  = '0;
      read_data_keep  = '1;
      read_data_last  = 1'b0;
      cur_addr = '0;
      total = 0;
      idx = 0;
      active = 1'b0;
      forever begin
         @(negedge clock);
         fire = read_data_valid && read_data_ready && !reset;
         @(posedge clock);
         #2;
         if (reset) begin
            active = 1'b0;
            pend_addr_q.delete();
            pend_len_q.delete();
         end else begin
            if (fire) begin
               idx++;
               cur_addr += 64'd64;
               if (idx >= total) active = 1'b0;
            end
            if (!active && pend_addr_q.size() > 0) begin
               cur_addr = pend_addr_q.pop_front();
               total    = int'(pend_len_q.pop_front() >> 6);
               idx      = 0;
               active   = (total > 0);
            end
         end
         read_data_valid = active;
         read_data_data  = {8{cur_addr}};
         read_data_last  = active && ((bad_last_beat >= 0) ? (idx == bad_last_beat) : (idx == total - 1));
      end
   end

   // Completion responder: raises back_valid once the oldest completion is due.
   initial begin
      back_valid = 1'b0;
      forever begin
         @(posedge clock);
         #2;
         if (reset) begin
            back_due_q.delete();
            back_valid = 1'b0;
         end else begin
            back_valid = (back_due_q.size() > 0) && (back_due_q[0] <= cycle_count);
         end
      end
   end

   task automatic clear_logs();
      rd_cmd_addr_q.delete();
      rd_cmd_len_q.delete();
      wr_cmd_addr_q.delete();
      wr_cmd_len_q.delete();
      wr_data_q.delete();
      wr_last_q.delete();
      rd_beat_count = 0;
      back_count    = 0;
      keep_bad      = 0;
   endtask

   task automatic do_job(input logic [63:0] s, input logic [63:0] d, input logic [31:0] l,
                         output logic [31:0] bursts, output logic err, output int backs,
                         output int wait_cycles, output bit ok);
      int n;
      ok = 1'b0;
      bursts = '0;
      err = 1'b0;
      backs = 0;
      wait_cycles = 0;
      @(posedge clock);
      #1;
      job_src_addr = s;
      job_dst_addr = d;
      job_length   = l;
      job_valid    = 1'b1;
      n = 0;
      do begin
         @(negedge clock);
         #1;
         n++;
      end while (!job_ready && n < 200);
      if (!job_ready) begin
         job_valid = 1'b0;
         return;
      end
      @(posedge clock);
      #1;
      job_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clock);
         #1;
         n++;
      end while (!done_valid && n < 5000);
      wait_cycles = n;
      if (!done_valid) return;
      bursts = done_bursts;
      err    = done_error;
      backs  = back_count;
      ok     = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      #1;
      checks_total++;
      if (job_ready !== 1'b0) $display("[TB] FAIL reset_job_ready: got %b expected 0", job_ready);
      else checks_passed++;
      checks_total++;
      if ({read_cmd_valid, write_cmd_valid, write_data_valid, done_valid} !== 4'b0000)
         $display("[TB] FAIL reset_valids: got %b expected 0000",
                  {read_cmd_valid, write_cmd_valid, write_data_valid, done_valid});
      else checks_passed++;
      checks_total++;
      if (read_data_ready !== 1'b1) $display("[TB] FAIL reset_fifo_empty: got %b expected 1", read_data_ready);
      else checks_passed++;
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(posedge clock);
      @(negedge clock);
      #1;
      checks_total++;
      if (job_ready !== 1'b1) $display("[TB] FAIL idle_job_ready: got %b expected 1", job_ready);
      else checks_passed++;
      checks_total++;
      if (back_ready !== 1'b1) $display("[TB] FAIL back_ready: got %b expected 1", back_ready);
      else checks_passed++;
      checks_total++;
      if ({read_cmd_address, write_cmd_length, done_bursts} !== 128'd0)
         $display("[TB] FAIL reset_regs: got %h %h %h expected 0", read_cmd_address, write_cmd_length, done_bursts);
      else checks_passed++;
   endtask

   task automatic test_single_burst();
      logic [31:0] b;
      logic        e;
      int          bk, wc, mism, lmism;
      bit          ok;
      logic [63:0] a;
      clear_logs();
      do_job(64'h1000, 64'h8000, 32'd4096, b, e, bk, wc, ok);
      checks_total++;
      if (ok !== 1'b1) $display("[TB] FAIL single_done: got %b expected 1", ok);
      else checks_passed++;
      checks_total++;
      if (rd_cmd_addr_q.size() !== 1 || rd_cmd_addr_q[0] !== 64'h1000 || rd_cmd_len_q[0] !== 32'd4096)
         $display("[TB] FAIL single_read_cmd: got %0d cmds expected 1 at 1000 len 4096", rd_cmd_addr_q.size());
      else checks_passed++;
      checks_total++;
      if (wr_cmd_addr_q.size() !== 1 || wr_cmd_addr_q[0] !== 64'h8000 || wr_cmd_len_q[0] !== 32'd4096)
         $display("[TB] FAIL single_write_cmd: got %0d cmds expected 1 at 8000 len 4096", wr_cmd_addr_q.size());
      else checks_passed++;
      checks_total++;
      if (wr_data_q.size() !== 64) $display("[TB] FAIL single_beats: got %0d expected 64", wr_data_q.size());
      else checks_passed++;
      mism = 0;
      lmism = 0;
      for (int i = 0; i < wr_data_q.size(); i++) begin
         a = 64'h1000 + 64'(i * 64);
         if (wr_data_q[i] !== {8{a}}) mism++;
         if (wr_last_q[i] !== (i == 63)) lmism++;
      end
      checks_total++;
      if (mism !== 0) $display("[TB] FAIL single_data: got %0d bad beats expected 0", mism);
      else checks_passed++;
      checks_total++;
      if (lmism !== 0) $display("[TB] FAIL single_last: got %0d misplaced last flags expected 0", lmism);
      else checks_passed++;
      checks_total++;
      if (keep_bad !== 0) $display("[TB] FAIL single_keep: got %0d partial keeps expected 0", keep_bad);
      else checks_passed++;
      checks_total++;
      if (b !== 32'd1 || e !== 1'b0) $display("[TB] FAIL single_result: got bursts %0d error %b expected 1 0", b, e);
      else checks_passed++;
      checks_total++;
      if (bk !== 1) $display("[TB] FAIL single_backs: got %0d expected 1", bk);
      else checks_passed++;
   endtask

   task automatic test_multi_burst();
      logic [31:0] b;
      logic        e;
      int          bk, wc, mism, lmism;
      bit          ok;
      logic [63:0] a;
      clear_logs();
      do_job(64'h1000, 64'h8000, 32'd10000, b, e, bk, wc, ok);
      checks_total++;
      if (ok !== 1'b1) $display("[TB] FAIL multi_done: got %b expected 1", ok);
      else checks_passed++;
      checks_total++;
      if (rd_cmd_addr_q.size() !== 3) $display("[TB] FAIL multi_read_count: got %0d expected 3", rd_cmd_addr_q.size());
      else checks_passed++;
      checks_total++;
      if (rd_cmd_addr_q.size() == 3 && (rd_cmd_addr_q[0] !== 64'h1000 || rd_cmd_addr_q[1] !== 64'h2000 ||
          rd_cmd_addr_q[2] !== 64'h3000 || rd_cmd_len_q[0] !== 32'd4096 || rd_cmd_len_q[1] !== 32'd4096 ||
          rd_cmd_len_q[2] !== 32'd1792))
         $display("[TB] FAIL multi_read_cmds: got last %h/%0d expected 3000/1792", rd_cmd_addr_q[2], rd_cmd_len_q[2]);
      else checks_passed++;
      checks_total++;
      if (wr_cmd_addr_q.size() !== 3 || wr_cmd_addr_q[0] !== 64'h8000 || wr_cmd_addr_q[1] !== 64'h9000 ||
          wr_cmd_addr_q[2] !== 64'hA000 || wr_cmd_len_q[2] !== 32'd1792)
         $display("[TB] FAIL multi_write_cmds: got %0d cmds expected 3 at 8000/9000/A000", wr_cmd_addr_q.size());
      else checks_passed++;
      checks_total++;
      if (wr_data_q.size() !== 156) $display("[TB] FAIL multi_beats: got %0d expected 156", wr_data_q.size());
      else checks_passed++;
      mism = 0;
      lmism = 0;
      for (int i = 0; i < wr_data_q.size(); i++) begin
         a = 64'h1000 + 64'(i * 64);
         if (wr_data_q[i] !== {8{a}}) mism++;
         if (wr_last_q[i] !== (i == 63 || i == 127 || i == 155)) lmism++;
      end
      checks_total++;
      if (mism !== 0) $display("[TB] FAIL multi_data: got %0d bad beats expected 0", mism);
      else checks_passed++;
      checks_total++;
      if (lmism !== 0) $display("[TB] FAIL multi_last: got %0d misplaced last flags expected 0", lmism);
      else checks_passed++;
      checks_total++;
      if (b !== 32'd3 || e !== 1'b0) $display("[TB] FAIL multi_result: got bursts %0d error %b expected 3 0", b, e);
      else checks_passed++;
      checks_total++;
      if (bk !== 3) $display("[TB] FAIL multi_backs_before_done: got %0d expected 3", bk);
      else checks_passed++;
   endtask

   task automatic test_backpressure();
      logic [31:0] b;
      logic        e;
      int          bk, wc, mism;
      bit          ok;
      logic [63:0] a;
      clear_logs();
      write_data_ready = 1'b0;
      fork
         do_job(64'h20000, 64'h40000, 32'd4096, b, e, bk, wc, ok);
         begin
            repeat (40) @(posedge clock);
            @(negedge clock);
            #1;
            checks_total++;
            if (rd_beat_count !== 16) $display("[TB] FAIL bp_buffered: got %0d expected 16", rd_beat_count);
            else checks_passed++;
            checks_total++;
            if (read_data_ready !== 1'b0) $display("[TB] FAIL bp_read_ready: got %b expected 0", read_data_ready);
            else checks_passed++;
            checks_total++;
            if (wr_data_q.size() !== 0) $display("[TB] FAIL bp_no_writes: got %0d expected 0", wr_data_q.size());
            else checks_passed++;
            @(posedge clock);
            #1;
            write_data_ready = 1'b1;
         end
      join
      checks_total++;
      if (ok !== 1'b1 || b !== 32'd1) $display("[TB] FAIL bp_done: got ok %b bursts %0d expected 1 1", ok, b);
      else checks_passed++;
      mism = 0;
      for (int i = 0; i < wr_data_q.size(); i++) begin
         a = 64'h20000 + 64'(i * 64);
         if (wr_data_q[i] !== {8{a}}) mism++;
      end
      checks_total++;
      if (wr_data_q.size() !== 64 || mism !== 0)
         $display("[TB] FAIL bp_data: got %0d beats %0d bad expected 64 0", wr_data_q.size(), mism);
      else checks_passed++;
   endtask

   task automatic test_zero_length();
      logic [31:0] lens [2];
      logic [31:0] b;
      logic        e;
      int          bk, wc;
      bit          ok;
      lens[0] = 32'd0;
      lens[1] = 32'd63;
      for (int k = 0; k < 2; k++) begin
         clear_logs();
         do_job(64'h5000, 64'h6000, lens[k], b, e, bk, wc, ok);
         checks_total++;
         if (ok !== 1'b1 || wc > 2) $display("[TB] FAIL zero_done_len%0d: got ok %b after %0d cycles expected 1 within 2", lens[k], ok, wc);
         else checks_passed++;
         checks_total++;
         if (b !== 32'd0 || e !== 1'b0) $display("[TB] FAIL zero_result_len%0d: got bursts %0d error %b expected 0 0", lens[k], b, e);
         else checks_passed++;
         checks_total++;
         if (rd_cmd_addr_q.size() + wr_cmd_addr_q.size() !== 0)
            $display("[TB] FAIL zero_cmds_len%0d: got %0d commands expected 0", lens[k], rd_cmd_addr_q.size() + wr_cmd_addr_q.size());
         else checks_passed++;
      end
   endtask

   task automatic test_last_error();
      logic [31:0] b;
      logic        e;
      int          bk, wc, mism, lmism;
      bit          ok;
      logic [63:0] a;
      clear_logs();
      bad_last_beat = 9;
      do_job(64'h1000, 64'h8000, 32'd4096, b, e, bk, wc, ok);
      bad_last_beat = -1;
      checks_total++;
      if (ok !== 1'b1 || e !== 1'b1) $display("[TB] FAIL err_flag: got ok %b error %b expected 1 1", ok, e);
      else checks_passed++;
      mism = 0;
      lmism = 0;
      for (int i = 0; i < wr_data_q.size(); i++) begin
         a = 64'h1000 + 64'(i * 64);
         if (wr_data_q[i] !== {8{a}}) mism++;
         if (wr_last_q[i] !== (i == 63)) lmism++;
      end
      checks_total++;
      if (wr_data_q.size() !== 64 || mism !== 0)
         $display("[TB] FAIL err_data: got %0d beats %0d bad expected 64 0", wr_data_q.size(), mism);
      else checks_passed++;
      checks_total++;
      if (lmism !== 0) $display("[TB] FAIL err_last: got %0d misplaced last flags expected 0", lmism);
      else checks_passed++;
   endtask

   task automatic test_reset_mid_job();
      logic [31:0] b;
      logic        e;
      int          bk, wc, n, mism;
      bit          ok;
      logic [63:0] a;
      clear_logs();
      @(posedge clock);
      #1;
      job_src_addr = 64'h7000;
      job_dst_addr = 64'hC000;
      job_length   = 32'd4096;
      job_valid    = 1'b1;
      n = 0;
      do begin
         @(negedge clock);
         #1;
         n++;
      end while (!job_ready && n < 200);
      @(posedge clock);
      #1;
      job_valid = 1'b0;
      n = 0;
      while (wr_data_q.size() < 5 && n < 500) begin
         @(negedge clock);
         #1;
         n++;
      end
      checks_total++;
      if (wr_data_q.size() < 5) $display("[TB] FAIL rst_reach_data: got %0d beats expected at least 5", wr_data_q.size());
      else checks_passed++;
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      #1;
      checks_total++;
      if ({read_cmd_valid, write_cmd_valid, write_data_valid, done_valid, job_ready} !== 5'b00000)
         $display("[TB] FAIL rst_valids: got %b expected 00000",
                  {read_cmd_valid, write_cmd_valid, write_data_valid, done_valid, job_ready});
      else checks_passed++;
      checks_total++;
      if (read_data_ready !== 1'b1) $display("[TB] FAIL rst_fifo_flushed: got %b expected 1", read_data_ready);
      else checks_passed++;
      @(posedge clock);
      #1;
      reset = 1'b0;
      clear_logs();
      do_job(64'h3000, 64'h9000, 32'd4096, b, e, bk, wc, ok);
      checks_total++;
      if (ok !== 1'b1 || b !== 32'd1 || e !== 1'b0 || bk !== 1)
         $display("[TB] FAIL rst_next_job: got ok %b bursts %0d error %b backs %0d expected 1 1 0 1", ok, b, e, bk);
      else checks_passed++;
      mism = 0;
      for (int i = 0; i < wr_data_q.size(); i++) begin
         a = 64'h3000 + 64'(i * 64);
         if (wr_data_q[i] !== {8{a}}) mism++;
      end
      checks_total++;
      if (wr_data_q.size() !== 64 || mism !== 0)
         $display("[TB] FAIL rst_next_data: got %0d beats %0d bad expected 64 0", wr_data_q.size(), mism);
      else checks_passed++;
   endtask

   initial begin
      job_valid        = 1'b0;
      job_src_addr     = '0;
      job_dst_addr     = '0;
      job_length       = '0;
      read_cmd_ready   = 1'b1;
      write_cmd_ready  = 1'b1;
      write_data_ready = 1'b1;
      done_ready       = 1'b1;
      test_reset();
      test_single_burst();
      test_multi_burst();
      test_backpressure();
      test_zero_length();
      test_last_error();
      test_reset_mid_job();
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
